gus16_xbus_ctl: RTL and testbench

External-bus sequencer and arbiter for the GUS16 core. It shares the 8-bit bidirectional uio pins between two 16-bit requesters, the CPU memory port and the serial loader. Each 16-bit access runs as a fixed sequence of byte phases: address high, address low, data high, data low. The block sits between the CPU/loader and the top-level pin mapping of tt_um_gus16.

---
 rtl/gus16_xbus_ctl_pkg.sv | 19 +
 rtl/gus16_xbus_ctl_if.sv | 38 +++
 rtl/gus16_xbus_ctl_rr_arb2.sv | 36 +++
 rtl/gus16_xbus_ctl.sv | 201 ++++++++++++++++++++
 tb/tb_gus16_xbus_ctl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gus16_xbus_ctl_pkg.sv
// Shared types and constants for the GUS16 external-bus sequencer.
package gus16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADRH = 3'd1,
        ST_ADRL = 3'd2,
        ST_DATH = 3'd3,
        ST_DATL = 3'd4,
        ST_ACK  = 3'd5
    } xbus_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

endpackage

// File: rtl/gus16_xbus_ctl_if.sv
// Requester ports and uio pin bundle of the GUS16 external bus.
// master: requesters plus the pin side (drive requests and bus_in).
// slave:  the sequencer itself.
interface gus16_xbus_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_ack;
    logic [15:0] rdata;
    logic [7:0]  bus_in;
    logic [7:0]  bus_out;
    logic [7:0]  bus_oe;
    logic        alh;
    logic        all;
    logic        rd_n;
    logic        wr_n;
    logic        bsel;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, bus_in,
        input  cpu_ack, ldr_ack, rdata,
        input  bus_out, bus_oe, alh, all, rd_n, wr_n, bsel
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, bus_in,
        output cpu_ack, ldr_ack, rdata,
        output bus_out, bus_oe, alh, all, rd_n, wr_n, bsel
    );
endinterface

// File: rtl/gus16_xbus_ctl_rr_arb2.sv
// Two-requester round-robin arbiter; req[0] is the CPU, req[1] the loader.
module gus16_rr_arb2
    import gus16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt,
    output logic       owner
);

    logic prio_ldr;

    // Grant the sole requester, or the favoured one on a tie.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_ldr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        owner = gnt[1] ? OWN_LDR : OWN_CPU;
    end

    // Favour the requester that lost, moving only when a grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ldr <= 1'b0;
        end else if (grant_en && (|gnt)) begin
            prio_ldr <= (owner == OWN_CPU);
        end
    end

endmodule

// File: rtl/gus16_xbus_ctl.sv
// GUS16 external-bus sequencer: arbitrates CPU/loader and runs each
// 16-bit access as four byte phases over the shared uio pins.
//
// state | meaning
// IDLE  | bus released, sample requests and latch the winner
// ADRH  | drive addr[15:8], alh high
// ADRL  | drive addr[7:0], all high
// DATH  | high data byte, 1+DATA_WS cycles, rd_n or wr_n low
// DATL  | low data byte, 1+DATA_WS cycles, rd_n or wr_n low
// ACK   | one-cycle ack to the owner
module gus16_xbus_ctl
    import gus16_pkg::*;
#(
    parameter int unsigned DATA_WS = 0
) (
    input logic        clk,
    input logic        rst_n,
    gus16_xbus_if.slave xb
);

    if (DATA_WS > 3) begin : g_bad_ws
        $error("DATA_WS must be in 0..3");
    end

    localparam logic [1:0] WS_LOAD = DATA_WS[1:0];

    xbus_state_t state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic        own_q, own_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic [1:0]  arb_gnt;
    logic        arb_owner;
    logic        grant_en;

    logic [7:0]  bus_out_d, bus_oe_d;
    logic        alh_d, all_d, rd_n_d, wr_n_d, bsel_d, cpu_ack_d, ldr_ack_d;

    assign grant_en = (state_q == ST_IDLE);
    assign xb.rdata = rdata_q;

    gus16_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({xb.ldr_req, xb.cpu_req}),
        .grant_en (grant_en),
        .gnt      (arb_gnt),
        .owner    (arb_owner)
    );

    // Next state, wait down-counter, request latch and read-byte capture.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        own_d   = own_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    state_d = ST_ADRH;
                    own_d   = arb_owner;
                    if (arb_owner == OWN_LDR) begin
                        we_d    = xb.ldr_we;
                        addr_d  = xb.ldr_addr;
                        wdata_d = xb.ldr_wdata;
                    end else begin
                        we_d    = xb.cpu_we;
                        addr_d  = xb.cpu_addr;
                        wdata_d = xb.cpu_wdata;
                    end
                end
            end
            ST_ADRH: state_d = ST_ADRL;
            ST_ADRL: begin
                state_d = ST_DATH;
                wait_d  = WS_LOAD;
            end
            ST_DATH: begin
                if (wait_q == 2'd0) begin
                    state_d = ST_DATL;
                    wait_d  = WS_LOAD;
                    if (!we_q) rdata_d[15:8] = xb.bus_in;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_DATL: begin
                if (wait_q == 2'd0) begin
                    state_d = ST_ACK;
                    if (!we_q) rdata_d[7:0] = xb.bus_in;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin values for the coming cycle, decoded from the next state so every output is a flop.
    always_comb begin
        bus_out_d = 8'h00;
        bus_oe_d  = OE_RELEASE;
        alh_d     = 1'b0;
        all_d     = 1'b0;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        bsel_d    = 1'b0;
        cpu_ack_d = 1'b0;
        ldr_ack_d = 1'b0;
        case (state_d)
            ST_ADRH: begin
                bus_out_d = addr_d[15:8];
                bus_oe_d  = OE_DRIVE;
                alh_d     = 1'b1;
            end
            ST_ADRL: begin
                bus_out_d = addr_d[7:0];
                bus_oe_d  = OE_DRIVE;
                all_d     = 1'b1;
            end
            ST_DATH: begin
                bsel_d = 1'b1;
                if (we_d) begin
                    bus_out_d = wdata_d[15:8];
                    bus_oe_d  = OE_DRIVE;
                    wr_n_d    = 1'b0;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            ST_DATL: begin
                if (we_d) begin
                    bus_out_d = wdata_d[7:0];
                    bus_oe_d  = OE_DRIVE;
                    wr_n_d    = 1'b0;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            ST_ACK: begin
                cpu_ack_d = (own_d == OWN_CPU);
                ldr_ack_d = (own_d == OWN_LDR);
            end
            default: ;
        endcase
    end

    // Sequencer state, wait counter and latched access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
            own_q   <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            own_q   <= own_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Registered pin and ack outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xb.bus_out <= 8'h00;
            xb.bus_oe  <= OE_RELEASE;
            xb.alh     <= 1'b0;
            xb.all     <= 1'b0;
            xb.rd_n    <= 1'b1;
            xb.wr_n    <= 1'b1;
            xb.bsel    <= 1'b0;
            xb.cpu_ack <= 1'b0;
            xb.ldr_ack <= 1'b0;
        end else begin
            xb.bus_out <= bus_out_d;
            xb.bus_oe  <= bus_oe_d;
            xb.alh     <= alh_d;
            xb.all     <= all_d;
            xb.rd_n    <= rd_n_d;
            xb.wr_n    <= wr_n_d;
            xb.bsel    <= bsel_d;
            xb.cpu_ack <= cpu_ack_d;
            xb.ldr_ack <= ldr_ack_d;
        end
    end

endmodule

// File: tb/tb_gus16_xbus_ctl.sv
// Bench for gus16_xbus_ctl: one instance with DATA_WS=0 and one with
// DATA_WS=2, each checked every cycle against a timing-schedule model.
module tb_gus16_xbus_ctl;
    import gus16_pkg::*;

    typedef struct packed {
        logic        cpu_req;
        logic        cpu_we;
        logic [15:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        ldr_req;
        logic        ldr_we;
        logic [15:0] ldr_addr;
        logic [15:0] ldr_wdata;
        logic [7:0]  bus_in;
    } in_t;

    typedef struct packed {
        logic [7:0]  bus_out;
        logic [7:0]  bus_oe;
        logic        alh;
        logic        all;
        logic        rd_n;
        logic        wr_n;
        logic        bsel;
        logic        cpu_ack;
        logic        ldr_ack;
        logic [15:0] rdata;
    } obs_t;

    typedef struct {
        logic        is_ldr;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_rdata;
    } vec_t;

    localparam int   WS_OF [2] = '{0, 2};
    localparam obs_t RST_OBS = '{bus_out: 8'h00, bus_oe: 8'h00, alh: 1'b0, all: 1'b0,
                                 rd_n: 1'b1, wr_n: 1'b1, bsel: 1'b0, cpu_ack: 1'b0,
                                 ldr_ack: 1'b0, rdata: 16'h0000};

    logic clk;
    logic rst_n;
    in_t  din [2];
    obs_t obs [2];

    gus16_xbus_if xb0 ();
    gus16_xbus_if xb2 ();

    assign xb0.cpu_req   = din[0].cpu_req;
    assign xb0.cpu_we    = din[0].cpu_we;
    assign xb0.cpu_addr  = din[0].cpu_addr;
    assign xb0.cpu_wdata = din[0].cpu_wdata;
    assign xb0.ldr_req   = din[0].ldr_req;
    assign xb0.ldr_we    = din[0].ldr_we;
    assign xb0.ldr_addr  = din[0].ldr_addr;
    assign xb0.ldr_wdata = din[0].ldr_wdata;
    assign xb0.bus_in    = din[0].bus_in;
    assign xb2.cpu_req   = din[1].cpu_req;
    assign xb2.cpu_we    = din[1].cpu_we;
    assign xb2.cpu_addr  = din[1].cpu_addr;
    assign xb2.cpu_wdata = din[1].cpu_wdata;
    assign xb2.ldr_req   = din[1].ldr_req;
    assign xb2.ldr_we    = din[1].ldr_we;
    assign xb2.ldr_addr  = din[1].ldr_addr;
    assign xb2.ldr_wdata = din[1].ldr_wdata;
    assign xb2.bus_in    = din[1].bus_in;

    assign obs[0] = {xb0.bus_out, xb0.bus_oe, xb0.alh, xb0.all, xb0.rd_n, xb0.wr_n,
                     xb0.bsel, xb0.cpu_ack, xb0.ldr_ack, xb0.rdata};
    assign obs[1] = {xb2.bus_out, xb2.bus_oe, xb2.alh, xb2.all, xb2.rd_n, xb2.wr_n,
                     xb2.bsel, xb2.cpu_ack, xb2.ldr_ack, xb2.rdata};

    gus16_xbus_ctl #(.DATA_WS(0)) dut0 (.clk(clk), .rst_n(rst_n), .xb(xb0));
    gus16_xbus_ctl #(.DATA_WS(2)) dut2 (.clk(clk), .rst_n(rst_n), .xb(xb2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: cycles since grant (k) decide the phase.
    logic        m_busy [2];
    int          m_k    [2];
    logic        m_own  [2];
    logic        m_last [2];
    logic        m_we   [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wdata[2];
    logic [15:0] m_rdata[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset(input int d);
        m_busy[d]  = 1'b0;
        m_k[d]     = 0;
        m_rdata[d] = 16'h0000;
        m_last[d]  = OWN_LDR;
    endfunction

    function automatic obs_t model_exp(input int d);
        obs_t e;
        int   ws;
        int   k;
        e       = RST_OBS;
        e.rdata = m_rdata[d];
        ws      = WS_OF[d];
        k       = m_k[d];
        if (m_busy[d]) begin
            if (k == 1) begin
                e.bus_out = m_addr[d][15:8];
                e.bus_oe  = 8'hFF;
                e.alh     = 1'b1;
            end else if (k == 2) begin
                e.bus_out = m_addr[d][7:0];
                e.bus_oe  = 8'hFF;
                e.all     = 1'b1;
            end else if (k <= 3 + ws) begin
                e.bsel = 1'b1;
                if (m_we[d]) begin
                    e.bus_out = m_wdata[d][15:8];
                    e.bus_oe  = 8'hFF;
                    e.wr_n    = 1'b0;
                end else begin
                    e.rd_n = 1'b0;
                end
            end else if (k <= 4 + 2 * ws) begin
                if (m_we[d]) begin
                    e.bus_out = m_wdata[d][7:0];
                    e.bus_oe  = 8'hFF;
                    e.wr_n    = 1'b0;
                end else begin
                    e.rd_n = 1'b0;
                end
            end else begin
                e.cpu_ack = (m_own[d] == OWN_CPU);
                e.ldr_ack = (m_own[d] == OWN_LDR);
            end
        end
        return e;
    endfunction

    // bus_out carries no meaning while the pins are released.
    function automatic logic bus_out_dc(input int d);
        int ws;
        ws = WS_OF[d];
        return m_busy[d] && ((m_k[d] >= 3 && m_k[d] <= 4 + 2 * ws && !m_we[d])
                             || m_k[d] == 5 + 2 * ws);
    endfunction

    function automatic void model_step(input int d);
        int ws;
        int k;
        ws = WS_OF[d];
        k  = m_k[d];
        if (m_busy[d]) begin
            if (!m_we[d] && k == 3 + ws)     m_rdata[d][15:8] = din[d].bus_in;
            if (!m_we[d] && k == 4 + 2 * ws) m_rdata[d][7:0]  = din[d].bus_in;
            if (k == 5 + 2 * ws) m_busy[d] = 1'b0;
            else                 m_k[d]    = k + 1;
        end else if (din[d].cpu_req || din[d].ldr_req) begin
            if (din[d].cpu_req && din[d].ldr_req)
                m_own[d] = (m_last[d] == OWN_CPU) ? OWN_LDR : OWN_CPU;
            else
                m_own[d] = din[d].ldr_req ? OWN_LDR : OWN_CPU;
            m_last[d] = m_own[d];
            if (m_own[d] == OWN_LDR) begin
                m_we[d]    = din[d].ldr_we;
                m_addr[d]  = din[d].ldr_addr;
                m_wdata[d] = din[d].ldr_wdata;
            end else begin
                m_we[d]    = din[d].cpu_we;
                m_addr[d]  = din[d].cpu_addr;
                m_wdata[d] = din[d].cpu_wdata;
            end
            m_busy[d] = 1'b1;
            m_k[d]    = 1;
        end
    endfunction

    // Check cycle outputs mid-cycle, advance the model, then return just after the next edge.
    task automatic step();
        obs_t a;
        obs_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) model_reset(d);
            a = obs[d];
            e = model_exp(d);
            if (bus_out_dc(d)) begin
                a.bus_out = 8'h00;
                e.bus_out = 8'h00;
            end
            chk($sformatf("cycle_ws%0d", WS_OF[d]), 64'(a), 64'(e));
            if (rst_n) model_step(d);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int ws;
        for (int d = 0; d < 2; d++) begin
            din[d]           = '0;
            din[d].cpu_addr  = 16'($urandom);
            din[d].ldr_addr  = 16'($urandom);
            din[d].cpu_wdata = 16'($urandom);
            din[d].ldr_wdata = 16'($urandom);
            if (v.is_ldr) begin
                din[d].ldr_req   = 1'b1;
                din[d].ldr_we    = v.we;
                din[d].ldr_addr  = v.addr;
                din[d].ldr_wdata = v.wdata;
            end else begin
                din[d].cpu_req   = 1'b1;
                din[d].cpu_we    = v.we;
                din[d].cpu_addr  = v.addr;
                din[d].cpu_wdata = v.wdata;
            end
        end
        for (int k = 0; k <= 10; k++) begin
            for (int d = 0; d < 2; d++) begin
                ws = WS_OF[d];
                if (k == 3 + ws)          din[d].bus_in = v.hi;
                else if (k == 4 + 2 * ws) din[d].bus_in = v.lo;
                else                      din[d].bus_in = 8'($urandom);
                if (k == 5 + 2 * ws) begin
                    din[d].cpu_req = 1'b0;
                    din[d].ldr_req = 1'b0;
                    chk($sformatf("vec%0d_ack_ws%0d", idx, ws),
                        64'({obs[d].cpu_ack, obs[d].ldr_ack}),
                        64'(v.is_ldr ? 2'b01 : 2'b10));
                    chk($sformatf("vec%0d_rdata_ws%0d", idx, ws),
                        64'(obs[d].rdata), 64'(v.exp_rdata));
                end
            end
            step();
        end
    endtask

    vec_t vecs [6];

    initial begin
        int ws;
        int p;

        vecs[0] = '{is_ldr: 1'b0, we: 1'b1, addr: 16'h1234, wdata: 16'hABCD, hi: 8'h00, lo: 8'h00, exp_rdata: 16'h0000};
        vecs[1] = '{is_ldr: 1'b1, we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, hi: 8'h5A, lo: 8'hC3, exp_rdata: 16'h5AC3};
        vecs[2] = '{is_ldr: 1'b0, we: 1'b1, addr: 16'h0000, wdata: 16'hFFFF, hi: 8'h11, lo: 8'h22, exp_rdata: 16'h5AC3};
        vecs[3] = '{is_ldr: 1'b0, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, hi: 8'h00, lo: 8'h81, exp_rdata: 16'h0081};
        vecs[4] = '{is_ldr: 1'b1, we: 1'b1, addr: 16'h8001, wdata: 16'h0F0F, hi: 8'h33, lo: 8'h44, exp_rdata: 16'h0081};
        vecs[5] = '{is_ldr: 1'b1, we: 1'b0, addr: 16'h7E7E, wdata: 16'h0000, hi: 8'hFF, lo: 8'hFF, exp_rdata: 16'hFFFF};

        rst_n  = 1'b0;
        din[0] = '0;
        din[1] = '0;
        for (int d = 0; d < 2; d++) model_reset(d);
        repeat (3) step();
        for (int d = 0; d < 2; d++)
            chk($sformatf("reset_state_ws%0d", WS_OF[d]), 64'(obs[d]), 64'(RST_OBS));
        rst_n = 1'b1;

        // Both requesters held high from reset: grants alternate, CPU first.
        for (int d = 0; d < 2; d++) begin
            din[d].cpu_req   = 1'b1;
            din[d].ldr_req   = 1'b1;
            din[d].cpu_we    = 1'b1;
            din[d].ldr_we    = 1'b1;
            din[d].cpu_addr  = 16'hC0C0;
            din[d].ldr_addr  = 16'h1D1D;
            din[d].cpu_wdata = 16'h0C0C;
            din[d].ldr_wdata = 16'hD1D1;
        end
        for (int c = 0; c < 30; c++) begin
            for (int d = 0; d < 2; d++) begin
                p = 6 + 2 * WS_OF[d];
                din[d].bus_in = 8'($urandom);
                if (c % p == p - 1)
                    chk($sformatf("rr_ack_ws%0d_c%0d", WS_OF[d], c),
                        64'({obs[d].cpu_ack, obs[d].ldr_ack}),
                        64'(((c / p) % 2 == 1) ? 2'b01 : 2'b10));
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            din[d].cpu_req = 1'b0;
            din[d].ldr_req = 1'b0;
        end
        repeat (12) step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // CPU drops its request during ADRL; the access still completes.
        for (int d = 0; d < 2; d++) begin
            din[d]          = '0;
            din[d].cpu_req  = 1'b1;
            din[d].cpu_addr = 16'h4242;
        end
        for (int k = 0; k <= 10; k++) begin
            for (int d = 0; d < 2; d++) begin
                ws = WS_OF[d];
                din[d].bus_in = 8'($urandom);
                if (k == 2) din[d].cpu_req = 1'b0;
                if (k == 5 + 2 * ws)
                    chk($sformatf("drop_ack_ws%0d", ws),
                        64'({obs[d].cpu_ack, obs[d].ldr_ack}), 64'(2'b10));
            end
            step();
        end

        // Reset asserted in the first DATH cycle of a write.
        for (int d = 0; d < 2; d++) begin
            din[d]           = '0;
            din[d].cpu_req   = 1'b1;
            din[d].cpu_we    = 1'b1;
            din[d].cpu_addr  = 16'hBEEF;
            din[d].cpu_wdata = 16'h1357;
            din[d].bus_in    = 8'($urandom);
        end
        repeat (3) step();
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            chk($sformatf("async_rst_ws%0d", WS_OF[d]), 64'(obs[d]), 64'(RST_OBS));
        step();
        rst_n = 1'b1;
        step();
        for (int d = 0; d < 2; d++)
            chk($sformatf("restart_adrh_ws%0d", WS_OF[d]),
                64'({obs[d].alh, obs[d].bus_out}), 64'({1'b1, 8'hBE}));
        for (int k = 1; k <= 10; k++) begin
            for (int d = 0; d < 2; d++) begin
                ws = WS_OF[d];
                if (k == 5 + 2 * ws) begin
                    din[d].cpu_req = 1'b0;
                    chk($sformatf("restart_ack_ws%0d", ws),
                        64'({obs[d].cpu_ack, obs[d].ldr_ack}), 64'(2'b10));
                end
            end
            step();
        end

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                din[d].cpu_req   = ($urandom_range(0, 2) != 0);
                din[d].ldr_req   = ($urandom_range(0, 2) != 0);
                din[d].cpu_we    = 1'($urandom);
                din[d].ldr_we    = 1'($urandom);
                din[d].cpu_addr  = 16'($urandom);
                din[d].ldr_addr  = 16'($urandom);
                din[d].cpu_wdata = 16'($urandom);
                din[d].ldr_wdata = 16'($urandom);
                din[d].bus_in    = 8'($urandom);
            end
            step();
        end
        for (int d = 0; d < 2; d++) din[d] = '0;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
